// File: rtl/ponpoko_input_ctrl.sv
// Player-input front end for the pacman core: PS/2 keys + two joysticks -> in0/in1, plus a timed coin pulse.
// Latency: joystick -> in0/in1 one cycle; PS/2 event -> in0/in1 two cycles; coin (in0[5]) lags FSM state by one cycle.
// Backpressure: none; outputs are refreshed every cycle and start requests arriving while busy are dropped.
//
// Ports:
//   CLK, RESET   system clock and synchronous active-high reset
//   ps2_key      [64] toggles per key event, [23:0] scancode bytes, [63:24] must be zero for a valid code
//   joystick_0/1 [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2, active high, OR-merged
//   in0          {2'b11, ~coin, fire, down, right, left, up}
//   in1          {1'b0, start2, start1, fire, down, right, left, up}
//   coin_busy    high while the coin FSM is in COIN or LOCK
module ponpoko_input_ctrl #(
   parameter int COIN_CYCLES     = 2400000,
   parameter int COOLDOWN_CYCLES = 4800000,
   parameter int CNT_W           = 24
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [64:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   output logic [7:0]  in0,
   output logic [7:0]  in1,
   output logic        coin_busy
);

   // A zero cooldown would skip LOCK's terminal cycle accounting; clamp to one.
   localparam int              COOL_EFF  = (COOLDOWN_CYCLES < 1) ? 1 : COOLDOWN_CYCLES;
   localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_EFF - 1);

   typedef enum logic [1:0] {S_IDLE, S_COIN, S_LOCK} coin_state_t;

   // ---------------- PS/2 decode ----------------
   logic       ps2_tog_q;
   logic       key_evt;
   logic       key_pressed;
   logic       key_ext;
   logic [8:0] key_code;

   always_comb begin
      key_evt     = (ps2_key[64] != ps2_tog_q);
      key_pressed = (ps2_key[15:8] != 8'hF0);
      // On a break the E0 prefix sits one byte further up, ahead of F0.
      key_ext     = key_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
      // Garbage in the upper bytes collapses to a code that matches nothing.
      key_code    = (|ps2_key[63:24]) ? 9'h000 : {key_ext, ps2_key[7:0]};
   end

   logic k_up, k_down, k_left, k_right, k_fire, k_start1, k_start2;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ps2_tog_q <= 1'b0;
         k_up      <= 1'b0;
         k_down    <= 1'b0;
         k_left    <= 1'b0;
         k_right   <= 1'b0;
         k_fire    <= 1'b0;
         k_start1  <= 1'b0;
         k_start2  <= 1'b0;
      end else begin
         ps2_tog_q <= ps2_key[64];
         if (key_evt) begin
            // Arrow keys: plain and E0-extended variants both map.
            case (key_code[7:0])
               8'h75:   k_up    <= key_pressed;
               8'h72:   k_down  <= key_pressed;
               8'h6B:   k_left  <= key_pressed;
               8'h74:   k_right <= key_pressed;
               default: ;
            endcase
            // Space and left ctrl share one fire latch, so releasing either clears it.
            case (key_code)
               9'h029, 9'h014: k_fire   <= key_pressed;
               9'h005:         k_start1 <= key_pressed;
               9'h006:         k_start2 <= key_pressed;
               default:        ;
            endcase
         end
      end
   end

   // ---------------- merge ----------------
   logic [15:0] joy;
   logic        m_up, m_down, m_left, m_right, m_fire, m_start1, m_start2;
   logic        m_req, m_req_q, m_rise;
   logic        unused_joy;

   assign joy        = joystick_0 | joystick_1;
   assign m_right    = k_right  | joy[0];
   assign m_left     = k_left   | joy[1];
   assign m_down     = k_down   | joy[2];
   assign m_up       = k_up     | joy[3];
   assign m_fire     = k_fire   | joy[4];
   assign m_start1   = k_start1 | joy[5];
   assign m_start2   = k_start2 | joy[6];
   assign m_req      = m_start1 | m_start2;
   assign m_rise     = m_req & ~m_req_q;
   assign unused_joy = &{1'b0, joy[15:7]};

   // ---------------- coin FSM ----------------
   coin_state_t      state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic             coin;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= S_IDLE;
         timer   <= '0;
         m_req_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         m_req_q <= m_req;
      end
   end

   // Rises seen in COIN or LOCK are simply ignored; only IDLE looks at m_rise.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      coin      = 1'b0;
      case (state)
         S_IDLE: begin
            if (m_rise) begin
               state_nxt = S_COIN;
               timer_nxt = COIN_LOAD;
            end
         end
         S_COIN: begin
            coin = 1'b1;
            if (timer != '0) begin
               timer_nxt = timer - CNT_W'(1);
            end else begin
               state_nxt = S_LOCK;
               timer_nxt = COOL_LOAD;
            end
         end
         S_LOCK: begin
            if (timer != '0) timer_nxt = timer - CNT_W'(1);
            else             state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign coin_busy = (state != S_IDLE);

   // ---------------- output registers ----------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         in0 <= 8'hE0;
         in1 <= 8'h00;
      end else begin
         in0 <= {2'b11, ~coin, m_fire, m_down, m_right, m_left, m_up};
         in1 <= {1'b0, m_start2, m_start1, m_fire, m_down, m_right, m_left, m_up};
      end
   end

endmodule

// File: tb/tb_ponpoko_input_ctrl.sv
// Bench for ponpoko_input_ctrl: directed scenarios followed by random joystick/PS/2/reset traffic.
// A per-cycle reference model pushes the expected in0/in1/coin_busy; a monitor pops and compares each negedge.
// The coin model tracks pulse start times rather than FSM states.
module tb_ponpoko_input_ctrl;
   localparam int C = 4;
   localparam int D = 8;
   localparam int K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3, K_FIRE = 4, K_S1 = 5, K_S2 = 6;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [64:0] ps2_key;
   logic [15:0] joystick_0, joystick_1;
   logic [7:0]  in0, in1;
   logic        coin_busy;

   always #5 CLK = ~CLK;

   ponpoko_input_ctrl #(.COIN_CYCLES(C), .COOLDOWN_CYCLES(D), .CNT_W(24)) dut (
      .CLK(CLK), .RESET(RESET), .ps2_key(ps2_key),
      .joystick_0(joystick_0), .joystick_1(joystick_1),
      .in0(in0), .in1(in1), .coin_busy(coin_busy)
   );

   typedef struct packed {
      logic [7:0] in0;
      logic [7:0] in1;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   int   edge_n    = 0;
   int   t0        = -1000000;   // edge at which the last accepted coin pulse began
   bit   held[7];
   bit   prev_tog  = 1'b0;
   bit   prev_mreq = 1'b0;

   logic [7:0] key_tbl [10] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06, 8'h1C, 8'h00};

   function automatic bit busy_at(int e);
      return (e >= t0) && (e < t0 + C + D);
   endfunction

   function automatic bit coin_at(int e);
      return (e >= t0) && (e < t0 + C);
   endfunction

   task automatic apply_key(input logic [64:0] k);
      bit pressed, ext;
      pressed = (k[15:8] != 8'hF0);
      ext     = pressed ? (k[15:8] == 8'hE0) : (k[23:16] == 8'hE0);
      if (k[63:24] == 40'h0) begin
         case (k[7:0])
            8'h75: held[K_UP]    = pressed;
            8'h72: held[K_DOWN]  = pressed;
            8'h6B: held[K_LEFT]  = pressed;
            8'h74: held[K_RIGHT] = pressed;
            8'h29, 8'h14: if (!ext) held[K_FIRE] = pressed;
            8'h05: if (!ext) held[K_S1] = pressed;
            8'h06: if (!ext) held[K_S2] = pressed;
            default: ;
         endcase
      end
   endtask

   // Predict what the DUT shows after the coming edge, then advance one cycle.
   task automatic tick();
      exp_t        e;
      logic [15:0] joy;
      bit          mu, md, ml, mr, mf, ms1, ms2, mreq, coin_prev;
      joy = joystick_0 | joystick_1;
      if (RESET) begin
         e.in0 = 8'hE0; e.in1 = 8'h00; e.busy = 1'b0;
         foreach (held[i]) held[i] = 1'b0;
         prev_tog  = 1'b0;
         prev_mreq = 1'b0;
         t0        = -1000000;
      end else begin
         mu  = held[K_UP]    | joy[3];
         md  = held[K_DOWN]  | joy[2];
         ml  = held[K_LEFT]  | joy[1];
         mr  = held[K_RIGHT] | joy[0];
         mf  = held[K_FIRE]  | joy[4];
         ms1 = held[K_S1]    | joy[5];
         ms2 = held[K_S2]    | joy[6];
         coin_prev = coin_at(edge_n - 1);
         mreq = ms1 | ms2;
         if (mreq && !prev_mreq && !busy_at(edge_n - 1)) t0 = edge_n;
         prev_mreq = mreq;
         e.in0  = {2'b11, ~coin_prev, mf, md, mr, ml, mu};
         e.in1  = {1'b0, ms2, ms1, mf, md, mr, ml, mu};
         e.busy = busy_at(edge_n);
         if (ps2_key[64] != prev_tog) apply_key(ps2_key);
         prev_tog = ps2_key[64];
      end
      exp_q.push_back(e);
      edge_n++;
      @(posedge CLK);
      #1;
   endtask

   task automatic ps2_evt(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0,
                          input logic [39:0] hi);
      ps2_key[63:0] = {hi, b2, b1, b0};
      ps2_key[64]   = ~ps2_key[64];
      tick();
   endtask

   function automatic logic [15:0] rand_joy();
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 5) != 0) v[5] = 1'b0;
      if ($urandom_range(0, 5) != 0) v[6] = 1'b0;
      return v;
   endfunction

   task automatic cmp(input string nm, input int cyc, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge.
   initial begin
      exp_t e;
      int   cyc;
      cyc = 0;
      @(posedge CLK);
      forever begin
         @(negedge CLK);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("in0", cyc, in0, e.in0);
            cmp("in1", cyc, in1, e.in1);
            cmp("coin_busy", cyc, {7'b0, coin_busy}, {7'b0, e.busy});
         end
      end
   end

   initial begin
      logic [7:0]  b0, b1, b2;
      logic [39:0] hi;
      int          r;
      RESET = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0;
      tick(); tick();
      RESET = 1'b0;
      repeat (3) tick();

      // Extended up make/break
      ps2_evt(8'h00, 8'hE0, 8'h75, 40'h0); repeat (3) tick();
      ps2_evt(8'hE0, 8'hF0, 8'h75, 40'h0); repeat (3) tick();

      // Coin pulse, dropped rise 6 cycles later, fresh rise after IDLE
      joystick_1[5] = 1'b1; tick(); joystick_1[5] = 1'b0; repeat (5) tick();
      joystick_0[6] = 1'b1; tick(); joystick_0[6] = 1'b0; repeat (20) tick();
      joystick_0[6] = 1'b1; tick(); joystick_0[6] = 1'b0; repeat (15) tick();

      // Shared fire latch and garbage upper bytes
      ps2_evt(8'h00, 8'h00, 8'h29, 40'h0); tick();
      ps2_evt(8'h00, 8'h00, 8'h14, 40'h0); tick();
      ps2_evt(8'h00, 8'hF0, 8'h14, 40'h0); repeat (2) tick();
      ps2_evt(8'h00, 8'h00, 8'h75, 40'h1); repeat (2) tick();
      ps2_evt(8'h00, 8'h00, 8'h72, 40'h0); repeat (2) tick();
      ps2_evt(8'h00, 8'hF0, 8'h72, 40'h0); repeat (2) tick();

      // Reset two cycles into COIN with start held
      joystick_0[5] = 1'b1; repeat (3) tick();
      RESET = 1'b1; tick(); RESET = 1'b0;
      repeat (20) tick();
      joystick_0[5] = 1'b0; repeat (15) tick();

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         RESET = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) joystick_0 = rand_joy();
         if ($urandom_range(0, 9) == 0) joystick_1 = rand_joy();
         r = $urandom_range(0, 7);
         if (r < 3) begin
            b0 = key_tbl[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
               0:       begin b2 = 8'($urandom); b1 = 8'h00; end
               1:       begin b2 = 8'h00;        b1 = 8'hE0; end
               2:       begin b2 = 8'h00;        b1 = 8'hF0; end
               default: begin b2 = 8'hE0;        b1 = 8'hF0; end
            endcase
            hi = ($urandom_range(0, 9) == 0) ? {8'h01, 32'($urandom)} : 40'h0;
            ps2_key[63:0] = {hi, b2, b1, b0};
            ps2_key[64]   = ~ps2_key[64];
         end else if (r == 3) begin
            // Data changes without a toggle must not register as an event.
            ps2_key[7:0] = key_tbl[$urandom_range(0, 9)];
         end
         tick();
      end
      RESET = 1'b0;
      repeat (4) tick();

      @(negedge CLK);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
